// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  // Controller FSM states
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  // ALU operand forwarding selects
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage : pipe_pkg

// File: rtl/pipe_fwd_sel.sv
// Single-operand forwarding select: EX/MEM beats MEM/WB, register 0 never forwards.
module pipe_fwd_sel
  import pipe_pkg::*;
#(
  parameter int unsigned RW = 5
) (
  input  logic [RW-1:0] src_i,
  input  logic [RW-1:0] exmem_rd_i,
  input  logic          exmem_regwrite_i,
  input  logic [RW-1:0] memwb_rd_i,
  input  logic          memwb_regwrite_i,
  output logic [1:0]    sel_o
);

  logic src_nz;

  assign src_nz = (src_i != '0);

  // Priority compare: youngest producer wins
  always_comb begin
    sel_o = FWD_RF;
    if (src_nz && exmem_regwrite_i && (exmem_rd_i == src_i)) begin
      sel_o = FWD_EXMEM;
    end else if (src_nz && memwb_regwrite_i && (memwb_rd_i == src_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule : pipe_fwd_sel

// File: rtl/pipe_hazard_ctrl.sv
// Stall / flush / forward controller for the 5-stage pipeline.
// Optional feature: define PIPE_FWD_EN to enable ALU operand forwarding
// (data hazards then reduce to the one-cycle load-use stall).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned RW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] idex_rs,
  input  logic [RW-1:0] idex_rt,
  input  logic [RW-1:0] idex_rd,
  input  logic          idex_regwrite,
  input  logic          idex_memread,
  input  logic [RW-1:0] exmem_rd,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic          memwb_regwrite,
  input  logic          ex_mc_start,
  input  logic          ex_br_taken,
  output logic          pc_we,
  output logic          ifid_we,
  output logic          ifid_flush,
  output logic          idex_we,
  output logic          idex_bubble,
  output logic          exmem_bubble,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          mc_busy
);

  localparam int unsigned CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 2);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          data_haz;
  logic [1:0]    fwd_a_raw, fwd_b_raw;

  // Nonzero register-ID equality
  function automatic logic reg_hit(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

`ifdef PIPE_FWD_EN
  pipe_fwd_sel #(.RW(RW)) u_fwd_a (
    .src_i            (idex_rs),
    .exmem_rd_i       (exmem_rd),
    .exmem_regwrite_i (exmem_regwrite),
    .memwb_rd_i       (memwb_rd),
    .memwb_regwrite_i (memwb_regwrite),
    .sel_o            (fwd_a_raw)
  );

  pipe_fwd_sel #(.RW(RW)) u_fwd_b (
    .src_i            (idex_rt),
    .exmem_rd_i       (exmem_rd),
    .exmem_regwrite_i (exmem_regwrite),
    .memwb_rd_i       (memwb_rd),
    .memwb_regwrite_i (memwb_regwrite),
    .sel_o            (fwd_b_raw)
  );

  // Only a load in EX cannot be forwarded in time
  assign data_haz = idex_memread && (reg_hit(id_rs, idex_rd) || reg_hit(id_rt, idex_rd));

  logic unused_cfg;
  assign unused_cfg = idex_regwrite;
`else
  assign fwd_a_raw = FWD_RF;
  assign fwd_b_raw = FWD_RF;

  // Without forwarding, wait for EX and MEM producers; WB writes before ID reads
  assign data_haz = (idex_regwrite  && (reg_hit(id_rs, idex_rd)  || reg_hit(id_rt, idex_rd))) ||
                    (exmem_regwrite && (reg_hit(id_rs, exmem_rd) || reg_hit(id_rt, exmem_rd)));

  logic unused_cfg;
  assign unused_cfg = ^{idex_rs, idex_rt, idex_memread, memwb_rd, memwb_regwrite};
`endif

  // State and multi-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and pipeline controls; priority rst > MC > branch > data hazard
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_we      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    mc_busy      = 1'b0;
    fwd_a        = fwd_a_raw;
    fwd_b        = fwd_b_raw;

    if (rst) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      fwd_a        = FWD_RF;
      fwd_b        = FWD_RF;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_mc_start) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_bubble = 1'b1;
            mc_busy      = 1'b1;
            state_d      = MC_WAIT;
            cnt_d        = CNT_LOAD;
          end else if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (data_haz) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MC_WAIT: begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_we      = 1'b0;
          exmem_bubble = 1'b1;
          mc_busy      = 1'b1;
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MC_LAT=4, RW=5).
module tb_pipe_hazard_ctrl;

  localparam int unsigned RW = 5;

  logic          clk;
  logic          rst;
  logic [RW-1:0] id_rs, id_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic          idex_regwrite, idex_memread, exmem_regwrite, memwb_regwrite;
  logic          ex_mc_start, ex_br_taken;
  logic          pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, mc_busy;
  logic [1:0]    fwd_a, fwd_b;

  int n_chk;
  int n_err;

  // Control vector: {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, mc_busy}
  localparam logic [6:0] C_RST   = 7'b0011110;
  localparam logic [6:0] C_NORM  = 7'b1101000;
  localparam logic [6:0] C_STALL = 7'b0001100;
  localparam logic [6:0] C_MC    = 7'b0000011;
  localparam logic [6:0] C_BR    = 7'b1111100;

`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  pipe_hazard_ctrl #(.MC_LAT(4), .RW(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .idex_rs        (idex_rs),
    .idex_rt        (idex_rt),
    .idex_rd        (idex_rd),
    .idex_regwrite  (idex_regwrite),
    .idex_memread   (idex_memread),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .ex_mc_start    (ex_mc_start),
    .ex_br_taken    (ex_br_taken),
    .pc_we          (pc_we),
    .ifid_we        (ifid_we),
    .ifid_flush     (ifid_flush),
    .idex_we        (idex_we),
    .idex_bubble    (idex_bubble),
    .exmem_bubble   (exmem_bubble),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .mc_busy        (mc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ctl();
    return {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, mc_busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = '0; id_rt = '0; idex_rs = '0; idex_rt = '0; idex_rd = '0;
    exmem_rd = '0; memwb_rd = '0;
    idex_regwrite = 1'b0; idex_memread = 1'b0;
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
    ex_mc_start = 1'b0; ex_br_taken = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    clear_in();

    // 1. reset held two cycles, then release
    rst = 1'b1;
    #1;
    chk("rst_ctl0", 32'(ctl()), 32'(C_RST));
    tick();
    chk("rst_ctl1", 32'(ctl()), 32'(C_RST));
    chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("run_ctl", 32'(ctl()), 32'(C_NORM));
    chk("run_fwd", 32'({fwd_a, fwd_b}), 32'd0);

    // 2. load-use: stalls in both builds for one cycle
    tick();
    idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd8; id_rs = 5'd8;
    #1;
    chk("lu_stall", 32'(ctl()), 32'(C_STALL));
    tick();
    clear_in(); id_rs = 5'd8;
    #1;
    chk("lu_after", 32'(ctl()), 32'(C_NORM));
    // ALU producer in EX: forwardable only with forwarding enabled
    idex_regwrite = 1'b1; idex_rd = 5'd8; id_rt = 5'd8; id_rs = 5'd0;
    #1;
    chk("alu_dep", 32'(ctl()), FWD ? 32'(C_NORM) : 32'(C_STALL));
    // register 0 never hazards
    idex_memread = 1'b1; idex_rd = 5'd0; id_rt = 5'd0;
    #1;
    chk("r0_haz", 32'(ctl()), 32'(C_NORM));

    // 3. forwarding selects
    tick();
    clear_in();
    idex_rs = 5'd5; idex_rt = 5'd5;
    exmem_rd = 5'd5; memwb_rd = 5'd5; exmem_regwrite = 1'b1; memwb_regwrite = 1'b1;
    #1;
    chk("fwd_a_exmem", 32'(fwd_a), FWD ? 32'd2 : 32'd0);
    chk("fwd_b_exmem", 32'(fwd_b), FWD ? 32'd2 : 32'd0);
    exmem_regwrite = 1'b0;
    #1;
    chk("fwd_a_memwb", 32'(fwd_a), FWD ? 32'd1 : 32'd0);
    idex_rt = 5'd6;
    #1;
    chk("fwd_b_none", 32'(fwd_b), 32'd0);
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0; idex_rs = 5'd0;
    #1;
    chk("fwd_a_r0", 32'(fwd_a), 32'd0);

    // 4. multi-cycle op: busy for exactly 4 cycles
    tick();
    clear_in(); ex_mc_start = 1'b1;
    #1;
    chk("mc_c0", 32'(ctl()), 32'(C_MC));
    tick();
    ex_mc_start = 1'b0; ex_br_taken = 1'b1;  // branch must not act while MC holds
    #1;
    chk("mc_c1", 32'(ctl()), 32'(C_MC));
    tick();
    ex_br_taken = 1'b0;
    #1;
    chk("mc_c2", 32'(ctl()), 32'(C_MC));
    tick();
    chk("mc_c3", 32'(ctl()), 32'(C_MC));
    tick();
    chk("mc_done", 32'(ctl()), 32'(C_NORM));

    // 5. taken branch overrides a load-use hazard
    idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd8; id_rs = 5'd8; ex_br_taken = 1'b1;
    #1;
    chk("br_ctl", 32'(ctl()), 32'(C_BR));
    tick();
    clear_in();
    #1;
    chk("br_after", 32'(ctl()), 32'(C_NORM));

    // 6. reset aborts a multi-cycle op at cnt=1
    ex_mc_start = 1'b1;
    #1;
    chk("abort_c0", 32'(ctl()), 32'(C_MC));
    tick();
    ex_mc_start = 1'b0;
    tick();
    #1;
    chk("abort_c2", 32'(ctl()), 32'(C_MC));
    rst = 1'b1;
    #1;
    chk("abort_rst", 32'(ctl()), 32'(C_RST));
    tick();
    rst = 1'b0;
    #1;
    chk("abort_run", 32'(ctl()), 32'(C_NORM));
    // producer in MEM: stall only without forwarding
    exmem_rd = 5'd3; exmem_regwrite = 1'b1; id_rt = 5'd3;
    #1;
    chk("mem_dep", 32'(ctl()), FWD ? 32'(C_NORM) : 32'(C_STALL));
    tick();
    clear_in();
    #1;
    chk("final_ctl", 32'(ctl()), 32'(C_NORM));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
